// File: rtl/arp_requester.sv
// ARP requester: broadcasts a request for target_ip, waits for a matching reply,
// retries on timeout and reports the resolved MAC or a one-cycle failure pulse.
module arp_requester #(
   parameter int unsigned TIMEOUT_CYCLES = 12_500_000,
   parameter int unsigned MAX_TRIES      = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        resolve,
   input  logic [31:0] target_ip,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic        rx_enable,
   input  logic [7:0]  rx_data,
   output logic        tx_request,
   input  logic        tx_enable,
   output logic [7:0]  tx_data,
   output logic        tx_active,
   output logic [47:0] destination_mac,
   output logic [47:0] resolved_mac,
   output logic        mac_valid,
   output logic        busy,
   output logic        fail
);

   localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);
   localparam logic [3:0]  TRIES_MAX = 4'(MAX_TRIES);
   localparam logic [63:0] RX_HEADER = 64'h0001_0800_0604_0002;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TXREQ = 2'd1;
   localparam logic [1:0] TX    = 2'd2;
   localparam logic [1:0] WAIT  = 2'd3;

   localparam logic [1:0] P_IDLE = 2'd0;
   localparam logic [1:0] P_RX   = 2'd1;
   localparam logic [1:0] P_ERR  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [3:0]             tries_q, tries_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [4:0]             tx_count_q, tx_count_d;
   logic [31:0]            target_ip_q, target_ip_d;
   logic [47:0]            resolved_mac_q, resolved_mac_d;
   logic                   mac_valid_q, mac_valid_d;
   logic                   fail_q, fail_d;

   logic [1:0]             p_state_q, p_state_d;
   logic [4:0]             offset_q, offset_d;
   logic [47:0]            sender_mac_q, sender_mac_d;

   logic [4:0]             cur_offset;
   logic [1:0]             sip_idx;
   logic [7:0]             exp_byte;
   logic                   check_byte;
   logic                   byte_ok;
   logic                   match;

   logic                   grant;
   logic [4:0]             tx_idx;
   logic [239:0]           tx_frame;

   // ---------------- transmit side ----------------
   assign grant      = (state_q == TXREQ) && tx_enable;
   assign tx_active  = grant || (state_q == TX);
   assign tx_idx     = grant ? 5'd0 : tx_count_q;
   assign tx_frame   = {80'h0806_0001_0800_0604_0001, local_mac, local_ip, 48'h0, target_ip_q};
   assign tx_data    = tx_active ? tx_frame[{5'd29 - tx_idx, 3'b000} +: 8] : 8'h00;
   assign tx_request = (state_q == TXREQ);

   assign destination_mac = 48'hFFFF_FFFF_FFFF;
   assign resolved_mac    = resolved_mac_q;
   assign mac_valid       = mac_valid_q;
   assign busy            = (state_q != IDLE);
   assign fail            = fail_q;

   // ---------------- receive parser ----------------
   // The first rx_enable cycle is seen while still in P_IDLE, so it is offset 0.
   assign cur_offset = (p_state_q == P_IDLE) ? 5'd0 : offset_q;
   assign sip_idx    = 2'(cur_offset - 5'd14);

   always_comb begin
      exp_byte   = 8'h00;
      check_byte = 1'b0;
      if (cur_offset < 5'd8) begin
         check_byte = 1'b1;
         exp_byte   = RX_HEADER[{3'd7 - cur_offset[2:0], 3'b000} +: 8];
      end else if (cur_offset >= 5'd14 && cur_offset < 5'd18) begin
         check_byte = 1'b1;
         exp_byte   = target_ip_q[{2'd3 - sip_idx, 3'b000} +: 8];
      end else if (cur_offset >= 5'd24) begin
         check_byte = 1'b1;
         exp_byte   = local_ip[{2'd3 - cur_offset[1:0], 3'b000} +: 8];
      end
   end

   assign byte_ok = !check_byte || (rx_data == exp_byte);
   assign match   = rx_enable && (p_state_q == P_RX) && (offset_q == 5'd27) && byte_ok;

   always_comb begin
      p_state_d    = p_state_q;
      offset_d     = offset_q;
      sender_mac_d = sender_mac_q;
      case (p_state_q)
         P_IDLE: begin
            if (rx_enable) begin
               if (byte_ok) begin
                  p_state_d = P_RX;
                  offset_d  = 5'd1;
               end else begin
                  p_state_d = P_ERR;
               end
            end
         end
         P_RX: begin
            if (!rx_enable) begin
               p_state_d = P_IDLE;
            end else if (!byte_ok || offset_q == 5'd27) begin
               // P_ERR also swallows trailing bytes after a complete packet.
               p_state_d = P_ERR;
            end else begin
               offset_d = offset_q + 5'd1;
               if (offset_q >= 5'd8 && offset_q < 5'd14) begin
                  sender_mac_d = {sender_mac_q[39:0], rx_data};
               end
            end
         end
         P_ERR: begin
            if (!rx_enable) p_state_d = P_IDLE;
         end
         default: p_state_d = P_IDLE;
      endcase
   end

   // ---------------- main FSM ----------------
   always_comb begin
      state_d        = state_q;
      tries_d        = tries_q;
      timer_d        = timer_q;
      tx_count_d     = tx_count_q;
      target_ip_d    = target_ip_q;
      resolved_mac_d = resolved_mac_q;
      mac_valid_d    = mac_valid_q;
      fail_d         = 1'b0;
      case (state_q)
         IDLE: begin
            if (resolve) begin
               target_ip_d = target_ip;
               mac_valid_d = 1'b0;
               tries_d     = 4'd1;
               state_d     = TXREQ;
            end
         end
         TXREQ: begin
            if (tx_enable) begin
               tx_count_d = 5'd1;
               state_d    = TX;
            end
         end
         TX: begin
            if (tx_count_q == 5'd29) begin
               timer_d = '0;
               state_d = WAIT;
            end else begin
               tx_count_d = tx_count_q + 5'd1;
            end
         end
         WAIT: begin
            // A reply completing on the terminal cycle beats the timeout.
            if (match) begin
               resolved_mac_d = sender_mac_q;
               mac_valid_d    = 1'b1;
               state_d        = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               if (tries_q < TRIES_MAX) begin
                  tries_d = tries_q + 4'd1;
                  state_d = TXREQ;
               end else begin
                  fail_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         tries_q        <= 4'd0;
         timer_q        <= '0;
         tx_count_q     <= 5'd0;
         target_ip_q    <= 32'h0;
         resolved_mac_q <= 48'h0;
         mac_valid_q    <= 1'b0;
         fail_q         <= 1'b0;
         p_state_q      <= P_IDLE;
         offset_q       <= 5'd0;
         sender_mac_q   <= 48'h0;
      end else begin
         state_q        <= state_d;
         tries_q        <= tries_d;
         timer_q        <= timer_d;
         tx_count_q     <= tx_count_d;
         target_ip_q    <= target_ip_d;
         resolved_mac_q <= resolved_mac_d;
         mac_valid_q    <= mac_valid_d;
         fail_q         <= fail_d;
         p_state_q      <= p_state_d;
         offset_q       <= offset_d;
         sender_mac_q   <= sender_mac_d;
      end
   end

endmodule
